// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 slave emulating a 32 x 8-bit register file with interrupt output.
// Local fabric port for register access and a per-byte write strobe for completed SPI writes.
module spi_reg_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int STATUS_REG  = 25,
  parameter int IEN_REG     = 26
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_spi_sclk,
  input  logic       i_spi_ss_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  input  logic [4:0] i_loc_addr,
  input  logic [7:0] i_loc_wdata,
  input  logic       i_loc_we,
  output logic [7:0] o_loc_rdata,
  output logic       o_wr_strobe,
  output logic [4:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_int_n,
  output logic       o_busy
);

  localparam logic [4:0] LP_STATUS = STATUS_REG[4:0];
  localparam logic [4:0] LP_IEN    = IEN_REG[4:0];

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_t;
  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic r_sclk_d, r_ss_d;
  logic w_sclk, w_ss, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  logic [7:0] r_regs [32];
  logic [6:0] r_shift_in;
  logic [7:0] r_shift_out;
  logic [2:0] r_bit_cnt;
  logic [4:0] r_addr;
  logic       r_oe;
  logic       r_wr_strobe;
  logic [4:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_loc_rdata;
  logic       r_int_n;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic       w_spi_we;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;

  // Completed byte includes the bit arriving on this rise.
  assign w_byte      = {r_shift_in, w_mosi};
  assign w_byte_done = (r_state != S_IDLE) && !w_ss_rise && w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_spi_we    = w_byte_done && (r_state == S_WR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_ss_fall) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_ss_rise)        w_state_nxt = S_IDLE;
        else if (w_byte_done) w_state_nxt = w_byte[1] ? S_WR : S_RD;
      end
      default: if (w_ss_rise) w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 8'h00;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_bit_cnt   <= '0;
      r_addr      <= '0;
      r_oe        <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_loc_rdata <= '0;
      r_int_n     <= 1'b1;
    end else begin
      r_wr_strobe <= 1'b0;
      r_loc_rdata <= r_regs[i_loc_addr];
      r_int_n     <= ~|(r_regs[LP_STATUS] & r_regs[LP_IEN]);
      // SPI write is issued last so it overrides a same-address local write.
      if (i_loc_we) r_regs[i_loc_addr] <= i_loc_wdata;
      if (w_spi_we) begin
        r_regs[r_addr] <= w_byte;
        r_wr_strobe    <= 1'b1;
        r_wr_addr      <= r_addr;
        r_wr_data      <= w_byte;
      end
      if (r_state == S_IDLE) begin
        if (w_ss_fall) begin
          r_shift_out <= r_regs[LP_STATUS];
          r_oe        <= 1'b1;
          r_bit_cnt   <= '0;
        end
      end else if (w_ss_rise) begin
        r_oe        <= 1'b0;
        r_shift_out <= '0;
      end else begin
        if (w_sclk_rise) begin
          r_shift_in <= {r_shift_in[5:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_state == S_CMD && r_bit_cnt == 3'd7) r_addr <= w_byte[7:3];
        end
        if (w_sclk_fall) begin
          if (r_bit_cnt != 3'd0)    r_shift_out <= {r_shift_out[6:0], 1'b0};
          else if (r_state == S_RD) r_shift_out <= r_regs[r_addr];
          else                      r_shift_out <= 8'h00;
        end
      end
    end
  end

  assign o_spi_miso    = r_shift_out[7];
  assign o_spi_miso_oe = r_oe;
  assign o_loc_rdata   = r_loc_rdata;
  assign o_wr_strobe   = r_wr_strobe;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_int_n       = r_int_n;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - scoreboard bench for spi_reg_responder with a register-array reference model.
module tb_spi_reg_responder;

  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, ss_n, mosi;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_we;
  logic       spi_miso, spi_miso_oe, wr_strobe, int_n, busy;
  logic [7:0] loc_rdata, wr_data;
  logic [4:0] wr_addr;

  spi_reg_responder #(.SYNC_STAGES(SYNC), .STATUS_REG(25), .IEN_REG(26)) dut (
    .i_clk(clk), .i_reset(reset), .i_spi_sclk(sclk), .i_spi_ss_n(ss_n), .i_spi_mosi(mosi),
    .o_spi_miso(spi_miso), .o_spi_miso_oe(spi_miso_oe),
    .i_loc_addr(loc_addr), .i_loc_wdata(loc_wdata), .i_loc_we(loc_we),
    .o_loc_rdata(loc_rdata), .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_int_n(int_n), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]  model [32];
  logic [7:0]  exp_miso_q [$];
  logic [12:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  bit          rd_pend = 1'b0;
  int          miso_cnt = 0;
  logic [7:0]  miso_sr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Local read and write-strobe monitor, sampled 1ns after the active edge.
  always @(posedge clk) begin
    logic [12:0] e;
    #1;
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL loc_rdata unexpected actual=0x%0h expected=none", loc_rdata);
      end else check("loc_rdata", 32'(loc_rdata), 32'(exp_rd_q.pop_front()));
    end
    if (wr_strobe) begin
      if (exp_wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_strobe unexpected actual=addr 0x%0h data 0x%0h expected=no strobe", wr_addr, wr_data);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[12:8]));
        check("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  // MISO byte monitor: master samples on the SCLK rise; select restarts the byte.
  always @(posedge sclk or negedge ss_n) begin
    if (!sclk) miso_cnt = 0;
    else if (!ss_n) begin
      miso_sr = {miso_sr[6:0], spi_miso};
      miso_cnt++;
      if (miso_cnt == 8) begin
        miso_cnt = 0;
        if (exp_miso_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL miso_byte unexpected actual=0x%0h expected=none", miso_sr);
        end else check("miso_byte", 32'(miso_sr), 32'(exp_miso_q.pop_front()));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit col,
                           input logic [4:0] ca, input logic [7:0] cd);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      wait_clk(HALF);
      sclk = 1'b1;
      if (col && i == 0) begin
        // Land the local write on the same edge the DUT commits the SPI byte.
        wait_clk(SYNC);
        loc_addr = ca; loc_wdata = cd; loc_we = 1'b1;
        wait_clk(1);
        loc_we = 1'b0;
        wait_clk(HALF - SYNC - 1);
      end else wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_txn(input logic [4:0] addr, input bit wr, input int nbytes, input logic [7:0] d0,
                         input int tail_bits, input bit col, input logic [4:0] ca, input logic [7:0] cd);
    logic [7:0] cmd, d;
    cmd = {addr, 1'($urandom), wr, 1'($urandom)};
    wait_clk(1);
    ss_n = 1'b0;
    wait_clk(HALF);
    check("busy_in_txn", 32'(busy), 1);
    check("oe_in_txn", 32'(spi_miso_oe), 1);
    exp_miso_q.push_back(model[25]);
    send_bits(cmd, 8, 1'b0, 5'd0, 8'd0);
    for (int k = 0; k < nbytes; k++) begin
      d = (k == 0) ? d0 : 8'($urandom);
      if (wr) begin
        exp_miso_q.push_back(8'h00);
        if (col && k == nbytes - 1) model[ca] = cd;
        model[addr] = d;
        exp_wr_q.push_back({addr, d});
      end else exp_miso_q.push_back(model[addr]);
      send_bits(d, 8, col && (k == nbytes - 1), ca, cd);
    end
    if (tail_bits > 0) send_bits(8'($urandom), tail_bits, 1'b0, 5'd0, 8'd0);
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(HALF);
    check("busy_after_txn", 32'(busy), 0);
    check("oe_after_txn", 32'(spi_miso_oe), 0);
    check("miso_after_txn", 32'(spi_miso), 0);
  endtask

  task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    model[a] = d;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic loc_read(input logic [4:0] a);
    @(negedge clk);
    loc_addr = a;
    exp_rd_q.push_back(model[a]);
    rd_pend = 1'b1;
    @(negedge clk);
    rd_pend = 1'b0;
  endtask

  task automatic check_int();
    wait_clk(2);
    check("int_n", 32'(int_n), 32'(~|(model[25] & model[26])));
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [4:0] a, ca;
    reset = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    loc_addr = '0; loc_wdata = '0; loc_we = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    check("reset_int_n", 32'(int_n), 1);
    check("reset_oe", 32'(spi_miso_oe), 0);
    check("reset_miso", 32'(spi_miso), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_wr_strobe", 32'(wr_strobe), 0);
    check("reset_wr_addr", 32'(wr_addr), 0);
    check("reset_wr_data", 32'(wr_data), 0);
    for (int i = 0; i < 32; i++) loc_read(5'(i));

    spi_txn(5'd1, 1'b1, 1, 8'h5C, 0, 1'b0, 5'd0, 8'd0);
    loc_read(5'd1);

    loc_write(5'd25, 8'h81);
    loc_write(5'd3, 8'hA5);
    spi_txn(5'd3, 1'b0, 2, 8'h00, 0, 1'b0, 5'd0, 8'd0);
    loc_read(5'd3);

    loc_write(5'd25, 8'h00);
    loc_write(5'd26, 8'h01);
    check_int();
    @(negedge clk);
    loc_addr = 5'd25; loc_wdata = 8'h01; loc_we = 1'b1;
    model[25] = 8'h01;
    @(posedge clk); #1;
    loc_we = 1'b0;
    check("int_n_same_edge", 32'(int_n), 1);
    @(posedge clk); #1;
    check("int_n_asserted", 32'(int_n), 0);
    loc_write(5'd25, 8'h00);
    check_int();

    spi_txn(5'd2, 1'b1, 0, 8'h00, 5, 1'b0, 5'd0, 8'd0);
    loc_read(5'd2);

    spi_txn(5'd4, 1'b1, 1, 8'h33, 0, 1'b1, 5'd4, 8'h77);
    loc_read(5'd4);
    spi_txn(5'd4, 1'b1, 1, 8'h33, 0, 1'b1, 5'd5, 8'h77);
    loc_read(5'd4);
    loc_read(5'd5);

    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom);
      ca = 5'($urandom);
      case ($urandom_range(0, 4))
        0: loc_write(a, 8'($urandom));
        1: spi_txn(a, 1'b1, $urandom_range(1, 3), 8'($urandom), 0, 1'b0, 5'd0, 8'd0);
        2: spi_txn(a, 1'b0, $urandom_range(1, 3), 8'h00, 0, 1'b0, 5'd0, 8'd0);
        3: spi_txn(a, 1'b1, $urandom_range(1, 2), 8'($urandom), 0, 1'b1, ca, 8'($urandom));
        default: spi_txn(a, 1'b1, $urandom_range(0, 1), 8'($urandom), $urandom_range(1, 7), 1'b0, 5'd0, 8'd0);
      endcase
      loc_read(a);
      loc_read(ca);
      check_int();
    end

    wait_clk(10);
    check("miso_q_drained", 32'(exp_miso_q.size()), 0);
    check("wr_q_drained", 32'(exp_wr_q.size()), 0);
    check("rd_q_drained", 32'(exp_rd_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 slave that sits on the other end of the SoC's SPI0 master and emulates a MAX3421E-style register interface: 32 x 8-bit register file plus interrupt output.
- Serves as a bench model and as an on-chip loopback target, so USB-driver software can run without the shield.
- Fabric side has a local register port and a per-byte write strobe.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on SCLK/MOSI/SS_n; minimum 2.
- STATUS_REG, 25, register shifted out on MISO during the command byte; also the interrupt-source register.
- IEN_REG, 26, interrupt-enable register; its bits are ANDed with STATUS_REG.

Ports:
- Clk  in  1  system clock; all logic runs on the rising edge.
- Reset  in  1  synchronous, active-high.
- spi_sclk  in  1  SPI clock; asynchronous to Clk and idles low.
- spi_ss_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  high while selected; the top level tristates MISO when this is low.
- loc_addr  in  5  local register address.
- loc_wdata  in  8  local write data.
- loc_we  in  1  local write enable.
- loc_rdata  out  8  local read data; registered, 1-cycle latency.
- wr_strobe  out  1  one-cycle pulse per completed SPI write byte.
- wr_addr  out  5  register written; valid while wr_strobe is high.
- wr_data  out  8  data written; valid while wr_strobe is high.
- int_n  out  1  low while (reg[STATUS_REG] & reg[IEN_REG]) != 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: FSM goes to IDLE.
  - All registers = 0x00.
  - Outputs: spi_miso = 0, spi_miso_oe = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, loc_rdata = 0, int_n = 1, busy = 0.
  - bit_cnt = 0.
  - Reset during a transaction aborts it with no register write.
- Synchronisation and edge detection:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronised stage with one extra flop.
  - The master must keep SCLK high and low for at least 4 Clk cycles each, and hold SS_n low for at least 4 Clk cycles before the first SCLK rise.
- Bit order and edges: MSB first. MOSI is sampled on the SCLK rise. MISO changes on the SCLK fall.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE -> CMD on the synchronised SS_n fall.
    - Load the shift-out register with reg[STATUS_REG].
    - Drive its MSB on spi_miso and set spi_miso_oe = 1 on that same Clk cycle.
    - Clear bit_cnt.
  - Each SCLK rise: shift the MOSI bit into shift_in and increment bit_cnt (3 bits, wraps 7 -> 0).
  - Each SCLK fall:
    - If bit_cnt != 0, shift out the next bit.
    - If bit_cnt == 0 (byte boundary), load a new out-byte: reg[addr] in RD, 0x00 in CMD or WR.
  - CMD, on the 8th rise: latch addr = cmd[7:3] and dir = cmd[1]. cmd[2] and cmd[0] are ignored.
    - dir = 1 -> WR.
    - dir = 0 -> RD.
  - WR, on each 8th rise:
    - reg[addr] <= byte.
    - wr_strobe = 1 for exactly one Clk cycle, with wr_addr and wr_data.
    - Stay in WR, same addr, with no auto-increment. Consecutive bytes overwrite the register and each one pulses wr_strobe.
  - RD: the register is re-read at each byte-boundary fall, so updates made mid-burst appear in the next byte. Incoming MOSI bytes are discarded.
  - Any state -> IDLE on the SS_n rise.
    - A partial byte (bit_cnt != 0) is discarded with no write.
    - spi_miso_oe = 0 and spi_miso = 0 on the next Clk cycle.
- Local port:
  - loc_rdata <= reg[loc_addr] every cycle.
  - loc_we writes the register on the next edge.
  - A local write and an SPI write in the same cycle to the same address: the SPI write wins. Different addresses: both take effect.
- int_n is registered, so it updates 1 cycle after a register change.
- busy = (state != IDLE).

Test Plan:
- Reset, then a local read of every address -> loc_rdata = 0x00; int_n = 1; spi_miso_oe = 0.
- SPI write: SS_n low, send 0x0A (addr 1, write), then 0x5C -> one wr_strobe pulse with wr_addr = 1 and wr_data = 0x5C; a local read of addr 1 returns 0x5C after 1 cycle.
- SPI read: local write reg[25] = 0x81, reg[3] = 0xA5; send cmd 0x18 (addr 3, read) plus two dummy bytes -> MISO bytes 0x81, 0xA5, 0xA5; no wr_strobe.
- Interrupt: reg[26] = 0x01, then reg[25] = 0x01 -> int_n = 0 one cycle later; reg[25] = 0x00 -> int_n = 1.
- Abort: cmd 0x12 (addr 2, write), then SS_n rises after 5 data bits -> reg[2] unchanged; no wr_strobe; state IDLE; spi_miso_oe = 0.
- Collision: an SPI write of 0x33 to addr 4 completes in the same cycle as loc_we writes 0x77 to addr 4 -> reg[4] = 0x33. A repeat of the burst with loc_addr = 5 -> reg[4] = 0x33 and reg[5] = 0x77.
